fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the asynchronous FIFO among NREQ requesters.
- Sits entirely in the write clock domain, directly in front of the FIFO write port (winc/wdata/wfull).
- Grants one requester at a time, in bursts of up to MAX_BURST beats.
- Stalls on wfull without losing or duplicating data.

Parameters:
- NREQ, 4: number of requesters (2..16).
- WIDTH, 8: data width; must match the FIFO WIDTH.
- MAX_BURST, 4: maximum beats one requester may write per grant (>=1).

Ports:
- wclk  in  1  write-domain clock.
- wrst  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester write request; level, held while data is valid.
- req_data  in  NREQ*WIDTH  per-requester data; requester i occupies bits [i*WIDTH +: WIDTH].
- wfull  in  1  FIFO full flag.
- gnt  out  NREQ  registered one-hot grant; all zero when idle.
- ack  out  NREQ  combinational: ack[i] = gnt[i] & req[i] & !wfull; the requester advances its data on ack.
- winc  out  1  FIFO write enable = |ack.
- wdata  out  WIDTH  req_data slice of the granted requester; zero when gnt == 0.
- busy  out  1  registered; high in state GRANT.

Behaviour:
- Interface: one clock, wclk. Reset wrst is asynchronous and active-high.
- Reset values: gnt=0, busy=0, ack=0, winc=0, wdata=0. State=IDLE, beat count=0, round-robin pointer last=NREQ-1, so requester 0 wins first.
- FSM states: IDLE, GRANT.
- IDLE:
  - If req != 0, pick the first set bit searching from last+1 upward, modulo NREQ.
  - Register gnt for that requester, set last to it, go to GRANT.
  - Arbitration latency: 1 cycle from req to gnt. No beat is written in the arbitration cycle.
- GRANT, per cycle:
  - If ack[g], beat count increments and the FIFO is written that cycle.
  - If wfull: no beat, count holds, grant holds. Grant is never revoked because of full.
- Release: grant ends at the clock edge after either event:
  - (a) req[g]==0 in a cycle, or
  - (b) the beat completing MAX_BURST beats is acked.
- Re-arbitration at release:
  - Done in the same cycle using the rotated priority with last=g, so g has lowest priority.
  - Other requester pending: gnt switches directly to it next cycle (no idle bubble); count resets to 0; state stays GRANT.
  - Only g still requesting (case b): g is re-granted with a fresh count.
  - No requests: go to IDLE, gnt=0.
- Beat counter width: $clog2(MAX_BURST+1); it never exceeds MAX_BURST.
- Requests arriving mid-burst wait; they do not pre-empt the current grant.
- Simultaneous release and new request on the same index: treated as pending (case b rule).
- wrst asserted mid-burst: all outputs return immediately to reset values. The beat in progress is lost on the arbiter side; the FIFO has its own reset.
- Fairness: with all NREQ requesting continuously, grant order is 0,1,...,NREQ-1,0..., each with MAX_BURST beats when the FIFO is not full.

Optional Feature:
- Macro: WARB_BEAT_CNT_EN.
- Defined:
  - Adds output beat_total[31:0], a registered count of all FIFO writes (increments on winc).
  - Saturates at 32'hFFFFFFFF; reset to 0 by wrst.
- Not defined: the port and counter do not exist. Other behaviour is identical.

Decomposition:
- Package warb_pkg:
  - State encoding constants ST_IDLE=1'b0, ST_GRANT=1'b1.
  - Helper function for the beat-counter width, clog2(MAX_BURST+1).
- One sub-module, warb_rr_pick: combinational rotate-and-priority-encode.
  - Inputs: req, last.
  - Outputs: one-hot pick and a valid flag.
  - Used in both IDLE and release arbitration.

Test Plan:
- Reset, then req=4'b0001, wfull=0, data held:
  - gnt=0001 one cycle after req.
  - 4 acks with winc=1 on consecutive cycles.
  - Then re-grant to 0 with a fresh burst (only requester).
- req=4'b1111 continuous, wfull=0:
  - Grant sequence 0001, 0010, 0100, 1000, 0001.
  - Exactly 4 winc per grant; no idle cycle between grants.
- req=4'b0011, wfull forced 1 for 5 cycles after first ack of requester 0:
  - ack=0, gnt stays 0001, count holds.
  - After wfull drops, 3 more beats, then gnt=0010.
- Requester 2 drops req after 2 beats while req[1] pending:
  - gnt moves to 0010 on next edge.
  - Total writes from 2 = 2; wdata tracks req_data slice 1.
- wrst pulse mid-burst:
  - gnt, busy, winc go 0 immediately.
  - After release, first grant goes to lowest index pending (last=NREQ-1).
- With WARB_BEAT_CNT_EN: after test 2 runs 40 cycles post-grant, beat_total equals the number of winc pulses; wrst clears it to 0.

Source files
------------

// File: rtl/warb_pkg.sv
// Shared definitions for the FIFO write-port arbiter.
//   warb_state_e    : arbiter FSM state encoding (ST_IDLE / ST_GRANT)
//   beat_cnt_width(): width of a beat counter that must hold 0..max_burst
// Optional feature macro used by the arbiter: WARB_BEAT_CNT_EN.
package warb_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } warb_state_e;

   // Counter must represent MAX_BURST itself, hence the +1.
   function automatic int unsigned beat_cnt_width(input int unsigned max_burst);
      return $clog2(max_burst + 1);
   endfunction

endpackage

// File: rtl/warb_rr_pick.sv
// Combinational round-robin pick: rotate the request vector so that the
// requester after last_i has highest priority, then priority-encode.
// Ports:
//   req_i   [NREQ]  request vector
//   last_i  [IdxW]  index granted most recently (lowest priority now)
//   pick_o  [NREQ]  one-hot winner, zero when no request
//   idx_o   [IdxW]  binary index of the winner
//   valid_o         at least one request present
module warb_rr_pick #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IdxW = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IdxW-1:0] last_i,
   output logic [NREQ-1:0] pick_o,
   output logic [IdxW-1:0] idx_o,
   output logic            valid_o
);

   always_comb begin
      int unsigned cand;
      cand    = 0;
      pick_o  = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      // Walk last+1, last+2, ... last+NREQ; last itself is visited last.
      for (int unsigned k = 1; k <= NREQ; k++) begin
         cand = (32'(last_i) + k) % NREQ;
         if (!valid_o && req_i[cand]) begin
            valid_o      = 1'b1;
            pick_o[cand] = 1'b1;
            idx_o        = cand[IdxW-1:0];
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the asynchronous FIFO's single write port among
// NREQ requesters, in bursts of up to MAX_BURST beats. Lives entirely in the
// write clock domain. Stalls on wfull without dropping or repeating beats.
// Optional feature macro: WARB_BEAT_CNT_EN (adds beat_total write counter).
// Ports:
//   wclk        write-domain clock
//   wrst        asynchronous active-high reset
//   req         per-requester level request
//   req_data    per-requester data, requester i at [i*WIDTH +: WIDTH]
//   wfull       FIFO full flag
//   gnt         registered one-hot grant, zero when idle
//   ack         gnt & req & !wfull, requester advances its data on it
//   winc        FIFO write enable
//   wdata       granted requester's data, zero when no grant
//   busy        registered, high while in ST_GRANT
//   beat_total  (WARB_BEAT_CNT_EN only) saturating count of FIFO writes
module fifo_wr_arbiter
   import warb_pkg::*;
#(
   parameter int unsigned NREQ      = 4,
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned MAX_BURST = 4
) (
   input  logic                  wclk,
   input  logic                  wrst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] req_data,
   input  logic                  wfull,
   output logic [NREQ-1:0]       gnt,
   output logic [NREQ-1:0]       ack,
   output logic                  winc,
   output logic [WIDTH-1:0]      wdata,
`ifdef WARB_BEAT_CNT_EN
   output logic [31:0]           beat_total,
`endif
   output logic                  busy
);

   localparam int unsigned IdxW = $clog2(NREQ);
   localparam int unsigned CntW = beat_cnt_width(MAX_BURST);

   warb_state_e     state_q, state_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [IdxW-1:0] gidx_q, gidx_d;
   logic [IdxW-1:0] last_q, last_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   logic [NREQ-1:0] pick_oh;
   logic [IdxW-1:0] pick_idx;
   logic            pick_valid;
   logic            burst_done;
   logic            grant_end;

   // last_q always equals the current grant index while granted, so one
   // picker serves both idle arbitration and release-time re-arbitration.
   warb_rr_pick #(
      .NREQ (NREQ),
      .IdxW (IdxW)
   ) u_pick (
      .req_i   (req),
      .last_i  (last_q),
      .pick_o  (pick_oh),
      .idx_o   (pick_idx),
      .valid_o (pick_valid)
   );

   // Outputs
   assign gnt  = gnt_q;
   assign busy = (state_q == ST_GRANT);
   assign ack  = gnt_q & req & {NREQ{~wfull}};
   assign winc = |ack;

   always_comb begin
      wdata = '0;
      if (|gnt_q) begin
         wdata = req_data[gidx_q*WIDTH +: WIDTH];
      end
   end

   // Grant ends when the holder drops its request, or on the acked beat
   // that completes the burst. A full FIFO never ends a grant.
   assign burst_done = winc && (cnt_q == CntW'(MAX_BURST - 1));
   assign grant_end  = !req[gidx_q] || burst_done;

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      gidx_d  = gidx_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (pick_valid) begin
               state_d = ST_GRANT;
               gnt_d   = pick_oh;
               gidx_d  = pick_idx;
               last_d  = pick_idx;
               cnt_d   = '0;
            end
         end
         ST_GRANT: begin
            if (grant_end) begin
               cnt_d = '0;
               if (pick_valid) begin
                  // Switch without an idle bubble; may re-grant the same
                  // requester when it is the only one still asking.
                  gnt_d  = pick_oh;
                  gidx_d = pick_idx;
                  last_d = pick_idx;
               end else begin
                  state_d = ST_IDLE;
                  gnt_d   = '0;
               end
            end else if (winc) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         state_q <= ST_IDLE;
         gnt_q   <= '0;
         gidx_q  <= '0;
         last_q  <= IdxW'(NREQ - 1);
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         gidx_q  <= gidx_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef WARB_BEAT_CNT_EN
   logic [31:0] beat_total_q, beat_total_d;

   always_comb begin
      beat_total_d = beat_total_q;
      if (winc && (beat_total_q != 32'hFFFF_FFFF)) begin
         beat_total_d = beat_total_q + 32'd1;
      end
   end

   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         beat_total_q <= '0;
      end else begin
         beat_total_q <= beat_total_d;
      end
   end

   assign beat_total = beat_total_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed testbench for fifo_wr_arbiter (NREQ=4, WIDTH=8, MAX_BURST=4).
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_fifo_wr_arbiter;

   logic        wclk;
   logic        wrst;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic        wfull;
   logic [3:0]  gnt;
   logic [3:0]  ack;
   logic        winc;
   logic [7:0]  wdata;
   logic        busy;
`ifdef WARB_BEAT_CNT_EN
   logic [31:0] beat_total;
`endif

   int checks;
   int errors;

   fifo_wr_arbiter #(
      .NREQ      (4),
      .WIDTH     (8),
      .MAX_BURST (4)
   ) dut (
      .wclk       (wclk),
      .wrst       (wrst),
      .req        (req),
      .req_data   (req_data),
      .wfull      (wfull),
      .gnt        (gnt),
      .ack        (ack),
      .winc       (winc),
      .wdata      (wdata),
`ifdef WARB_BEAT_CNT_EN
      .beat_total (beat_total),
`endif
      .busy       (busy)
   );

   initial wclk = 1'b0;
   always #5 wclk = ~wclk;

   task automatic test_reset();
      @(negedge wclk);
      wrst  = 1'b1;
      req   = 4'b1111;
      wfull = 1'b0;
      #1;
      checks++;
      if (gnt !== 4'b0000) begin
         errors++;
         $display("FAIL reset_gnt: got %b expected %b", gnt, 4'b0000);
      end
      checks++;
      if ({busy, winc, ack} !== 6'b0) begin
         errors++;
         $display("FAIL reset_busy_winc_ack: got %b expected %b", {busy, winc, ack}, 6'b0);
      end
      checks++;
      if (wdata !== 8'h00) begin
         errors++;
         $display("FAIL reset_wdata: got %h expected %h", wdata, 8'h00);
      end
`ifdef WARB_BEAT_CNT_EN
      checks++;
      if (beat_total !== 32'd0) begin
         errors++;
         $display("FAIL reset_beat_total: got %0d expected %0d", beat_total, 0);
      end
`endif
      @(negedge wclk);
      req = 4'b0000;
      @(negedge wclk);
      wrst = 1'b0;
   endtask

   task automatic test_single();
      @(negedge wclk);
      req = 4'b0001;
      #1;
      checks++;
      if ({gnt, winc} !== 5'b0) begin
         errors++;
         $display("FAIL single_arb_cycle: got %b expected %b", {gnt, winc}, 5'b0);
      end
      // Four beats of burst one, then a fresh burst for the same requester.
      for (int k = 0; k < 6; k++) begin
         @(negedge wclk);
         #1;
         checks++;
         if ({gnt, winc, busy, wdata} !== {4'b0001, 1'b1, 1'b1, 8'hA0}) begin
            errors++;
            $display("FAIL single_beat%0d: got gnt=%b winc=%b busy=%b wdata=%h expected 0001 1 1 a0",
                     k, gnt, winc, busy, wdata);
         end
      end
      @(negedge wclk);
      req = 4'b0000;
      #1;
      checks++;
      if (winc !== 1'b0) begin
         errors++;
         $display("FAIL single_drop_winc: got %b expected 0", winc);
      end
      @(negedge wclk);
      #1;
      checks++;
      if ({gnt, busy} !== 5'b0) begin
         errors++;
         $display("FAIL single_idle: got %b expected %b", {gnt, busy}, 5'b0);
      end
   endtask

   task automatic test_fairness();
      int wincs;
      int idx;
      logic [3:0] exp_gnt;
      logic [7:0] exp_data;
      wincs = 0;
      @(negedge wclk);
      req = 4'b1111;
      #1;
      checks++;
      if (gnt !== 4'b0000) begin
         errors++;
         $display("FAIL fair_arb_cycle: got %b expected 0000", gnt);
      end
      for (int i = 0; i < 40; i++) begin
         @(negedge wclk);
         #1;
         idx      = (i / 4) % 4;
         exp_gnt  = 4'b0001 << idx;
         exp_data = 8'hA0 + 8'(idx);
         if (winc === 1'b1) wincs++;
         checks++;
         if ({gnt, winc, wdata} !== {exp_gnt, 1'b1, exp_data}) begin
            errors++;
            $display("FAIL fair_cycle%0d: got gnt=%b winc=%b wdata=%h expected %b 1 %h",
                     i, gnt, winc, wdata, exp_gnt, exp_data);
         end
      end
      @(negedge wclk);
      #1;
      checks++;
      if (wincs !== 40) begin
         errors++;
         $display("FAIL fair_winc_count: got %0d expected %0d", wincs, 40);
      end
`ifdef WARB_BEAT_CNT_EN
      checks++;
      if (beat_total !== 32'd40) begin
         errors++;
         $display("FAIL fair_beat_total: got %0d expected %0d", beat_total, 40);
      end
`endif
      req = 4'b0000;
   endtask

   task automatic test_wfull();
      @(negedge wclk);
      req = 4'b0011;
      @(negedge wclk);
      #1;
      checks++;
      if ({gnt, ack} !== {4'b0001, 4'b0001}) begin
         errors++;
         $display("FAIL full_first_ack: got gnt=%b ack=%b expected 0001 0001", gnt, ack);
      end
      for (int k = 0; k < 5; k++) begin
         @(negedge wclk);
         wfull = 1'b1;
         #1;
         checks++;
         if ({gnt, ack, winc} !== {4'b0001, 4'b0000, 1'b0}) begin
            errors++;
            $display("FAIL full_stall%0d: got gnt=%b ack=%b winc=%b expected 0001 0000 0",
                     k, gnt, ack, winc);
         end
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge wclk);
         wfull = 1'b0;
         #1;
         checks++;
         if ({gnt, ack} !== {4'b0001, 4'b0001}) begin
            errors++;
            $display("FAIL full_resume%0d: got gnt=%b ack=%b expected 0001 0001", k, gnt, ack);
         end
      end
      @(negedge wclk);
      #1;
      checks++;
      if ({gnt, ack, wdata} !== {4'b0010, 4'b0010, 8'hA1}) begin
         errors++;
         $display("FAIL full_switch: got gnt=%b ack=%b wdata=%h expected 0010 0010 a1",
                  gnt, ack, wdata);
      end
      req = 4'b0000;
   endtask

   task automatic test_drop();
      int writes2;
      writes2 = 0;
      @(negedge wclk);
      req = 4'b0100;
      @(negedge wclk);
      #1;
      if (ack[2] === 1'b1) writes2++;
      checks++;
      if ({gnt, wdata} !== {4'b0100, 8'hA2}) begin
         errors++;
         $display("FAIL drop_gnt2: got gnt=%b wdata=%h expected 0100 a2", gnt, wdata);
      end
      @(negedge wclk);
      req = 4'b0110;
      #1;
      if (ack[2] === 1'b1) writes2++;
      checks++;
      if (gnt !== 4'b0100) begin
         errors++;
         $display("FAIL drop_no_preempt: got %b expected 0100", gnt);
      end
      @(negedge wclk);
      req = 4'b0010;
      #1;
      if (ack[2] === 1'b1) writes2++;
      checks++;
      if ({gnt, winc} !== {4'b0100, 1'b0}) begin
         errors++;
         $display("FAIL drop_cycle: got gnt=%b winc=%b expected 0100 0", gnt, winc);
      end
      @(negedge wclk);
      #1;
      checks++;
      if ({gnt, winc, wdata} !== {4'b0010, 1'b1, 8'hA1}) begin
         errors++;
         $display("FAIL drop_switch: got gnt=%b winc=%b wdata=%h expected 0010 1 a1",
                  gnt, winc, wdata);
      end
      checks++;
      if (writes2 !== 2) begin
         errors++;
         $display("FAIL drop_writes2: got %0d expected %0d", writes2, 2);
      end
      req = 4'b0000;
   endtask

   task automatic test_mid_reset();
      @(negedge wclk);
      req = 4'b1111;
      @(negedge wclk);
      #1;
      checks++;
      if (gnt !== 4'b0001) begin
         errors++;
         $display("FAIL mrst_first_gnt: got %b expected 0001", gnt);
      end
      @(negedge wclk);
      #1;
      wrst = 1'b1;
      #1;
      checks++;
      if ({gnt, busy, winc, wdata} !== 14'b0) begin
         errors++;
         $display("FAIL mrst_async: got gnt=%b busy=%b winc=%b wdata=%h expected all zero",
                  gnt, busy, winc, wdata);
      end
`ifdef WARB_BEAT_CNT_EN
      checks++;
      if (beat_total !== 32'd0) begin
         errors++;
         $display("FAIL mrst_beat_total: got %0d expected 0", beat_total);
      end
`endif
      @(negedge wclk);
      wrst = 1'b0;
      req  = 4'b0110;
      #1;
      checks++;
      if (gnt !== 4'b0000) begin
         errors++;
         $display("FAIL mrst_arb_cycle: got %b expected 0000", gnt);
      end
      @(negedge wclk);
      #1;
      checks++;
      if ({gnt, busy, wdata} !== {4'b0010, 1'b1, 8'hA1}) begin
         errors++;
         $display("FAIL mrst_regrant: got gnt=%b busy=%b wdata=%h expected 0010 1 a1",
                  gnt, busy, wdata);
      end
      req = 4'b0000;
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      wrst     = 1'b1;
      req      = 4'b0000;
      wfull    = 1'b0;
      req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      test_reset();
      test_single();
      test_reset();
      test_fairness();
      test_reset();
      test_wfull();
      test_reset();
      test_drop();
      test_reset();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
